alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
Sequencer and arbiter that shares the single combinational ALU between the CPU core and the DMA module. It accepts one operation per requester through a req/done handshake and latches opcode and operands. It drives the ALU for a fixed number of cycles, with extra cycles for MUL, then registers result and flags back to the winning requester. Round-robin arbitration prevents either master starving the other.

Parameters:
MUL_CYCLES, 2, EXEC cycles spent on opcode 3'b010 (MUL); legal range 1..15
ALU_CYCLES, 1, EXEC cycles spent on all other opcodes; legal range 1..15

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cpu_req  input  1  CPU requests an operation; held with stable operands until cpu_done
cpu_opcode  input  3  CPU operation code (ALU encoding 000 ADD .. 111 XOR)
cpu_a  input  32  CPU operand 1
cpu_b  input  32  CPU operand 2
cpu_gnt  output  1  one-cycle pulse: CPU request accepted, operands latched
cpu_done  output  1  one-cycle pulse: result/flags valid for CPU
dma_req, dma_opcode, dma_a, dma_b, dma_gnt, dma_done  same as cpu_* for DMA
res  output  32  registered result, valid while either done is high, held afterwards
flag_c  output  1  registered carry flag from ALU
flag_z  output  1  registered zero flag from ALU
busy  output  1  high whenever the state is not IDLE
alu_opcode  output  3  to ALU opcode
alu_op1  output  32  to ALU operand1
alu_op2  output  32  to ALU operand2
alu_result  input  32  from ALU result
alu_flagC  input  1  from ALU flagC
alu_flagZ  input  1  from ALU flagZ

Behaviour:
- Reset (async, rst_n=0): state IDLE; all gnt/done=0; res=0; flag_c=0; flag_z=0; busy=0; latched opcode/operands=0, so alu_opcode=000 and alu_op1/alu_op2=0; rr pointer = CPU-first. Reset during EXEC/RESP aborts silently: no done is issued and the requester must re-request.
- alu_opcode/alu_op1/alu_op2 driven only from internal latch registers, never directly from requester ports.
- States: IDLE, EXEC, RESP.
- IDLE: if no req, stay. If only one req, grant it. If both, grant the side indicated by the rr pointer. On the grant edge: latch opcode/a/b and owner; load cnt = (opcode==MUL ? MUL_CYCLES : ALU_CYCLES) - 1; go to EXEC. The owner's gnt is high for exactly the first EXEC cycle.
- EXEC: if cnt!=0, decrement. If cnt==0, on the edge capture alu_result->res, alu_flagC->flag_c, alu_flagZ->flag_z, go to RESP, and set the rr pointer to the non-owner.
- RESP: owner's done high for exactly this one cycle; next state IDLE unconditionally. The request is sampled again in IDLE on the following cycle.
- Latency, non-MUL with default parameters: req sampled in cycle 0, gnt in cycle 1, done in cycle 2. MUL: done in cycle 1+MUL_CYCLES. Throughput for back-to-back requests from one master is one op per ALU_CYCLES+2 cycles.
- Requester must drop req in its done cycle. If req is still high in the following IDLE cycle, it is a new transaction.
- A req withdrawn after gnt does not abort the operation: the transaction completes and done still pulses.
- A non-owner's req held during EXEC/RESP is queued implicitly. It wins the next IDLE cycle by round-robin, even if the owner re-requests in that same cycle.
- cpu_gnt and dma_gnt are never high together; likewise cpu_done and dma_done.
- res/flags are held until the next capture. Flags are pass-through of the ALU (carry semantics owned by the ALU).
- Request-port changes after gnt have no effect on the operation in flight.

Test Plan:
- Reset: assert rst_n=0 mid-EXEC of a CPU ADD -> all outputs 0 immediately, no cpu_done. After release, busy=0 and the pointer is CPU-first.
- Single CPU ADD: cpu_a=5, cpu_b=7, opcode 000 -> cpu_gnt in cycle 1, cpu_done in cycle 2, res=12, flag_z=0, dma_* stay 0.
- DMA MUL with MUL_CYCLES=2: dma_a=3, dma_b=4, opcode 010 -> dma_gnt in cycle 1, dma_done in cycle 3, res=12. alu_op1/op2 stable at 3/4 throughout EXEC even after dma_a is changed to 9 in cycle 2.
- Simultaneous requests after reset: CPU SUB 10-10, DMA XOR 0xF0^0x0F both held -> CPU served first (res=0, flag_z=1, cpu_done in cycle 2). DMA gnt in cycle 4, dma_done in cycle 5 with res=0xFF.
- Fairness: both req held continuously and each dropped only in its own done cycle, then re-raised -> grants strictly alternate CPU, DMA, CPU, DMA over 8 transactions; no overlapping gnt/done pulses.
- Withdrawn request: CPU AND 0xFFFF&0x00FF, cpu_req dropped in the gnt cycle -> cpu_done still pulses in cycle 2 with res=0x00FF. The next IDLE cycle shows busy=0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter
// Shares one combinational ALU between the CPU core and the DMA engine.
// Each requester hands over one operation through a req/gnt/done handshake.
// Opcode and operands are latched at grant, so the ALU inputs never follow
// the requester ports. The latched operation is held on the ALU for
// ALU_CYCLES cycles (MUL_CYCLES for MUL). The ALU outputs are then
// registered and returned to the owner. A round-robin pointer decides
// which side wins when both sides request together.
//
// Ports
//   clk, rst_n                         clock, async active-low reset
//   cpu_req/opcode/a/b -> cpu_gnt/done CPU request channel
//   dma_req/opcode/a/b -> dma_gnt/done DMA request channel
//   res, flag_c, flag_z                registered result/flags, held until next op
//   busy                               high whenever the sequencer is not idle
//   alu_opcode/op1/op2                 latched operation driven to the ALU
//   alu_result/flagC/flagZ             combinational ALU outputs
//
// state | meaning
// IDLE  | waiting for a request; arbitrates and latches the winner's operation
// EXEC  | ALU driven from the latches; cnt counts the remaining cycles down
// RESP  | result registered; owner's done pulses for this one cycle

module alu_arbiter #(
    parameter int unsigned MUL_CYCLES = 2,
    parameter int unsigned ALU_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        cpu_req,
    input  logic [2:0]  cpu_opcode,
    input  logic [31:0] cpu_a,
    input  logic [31:0] cpu_b,
    output logic        cpu_gnt,
    output logic        cpu_done,

    input  logic        dma_req,
    input  logic [2:0]  dma_opcode,
    input  logic [31:0] dma_a,
    input  logic [31:0] dma_b,
    output logic        dma_gnt,
    output logic        dma_done,

    output logic [31:0] res,
    output logic        flag_c,
    output logic        flag_z,
    output logic        busy,

    output logic [2:0]  alu_opcode,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    input  logic [31:0] alu_result,
    input  logic        alu_flagC,
    input  logic        alu_flagZ
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_MUL   = 3'b010;
    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);
    localparam logic [3:0] ALU_LOAD = 4'(ALU_CYCLES - 1);

    state_t      state_q,    state_d;
    logic [3:0]  cnt_q,      cnt_d;
    logic [2:0]  op_q,       op_d;
    logic [31:0] a_q,        a_d;
    logic [31:0] b_q,        b_d;
    logic        owner_q,    owner_d;     // 0 = CPU, 1 = DMA
    logic        rr_q,       rr_d;        // 0 = CPU wins a tie, 1 = DMA wins
    logic        cpu_gnt_q,  cpu_gnt_d;
    logic        dma_gnt_q,  dma_gnt_d;
    logic        cpu_done_q, cpu_done_d;
    logic        dma_done_q, dma_done_d;
    logic [31:0] res_q,      res_d;
    logic        fc_q,       fc_d;
    logic        fz_q,       fz_d;

    logic        win_cpu;
    logic        win_dma;
    logic [2:0]  win_op;

    // A lone request always wins; on a tie the round-robin pointer decides.
    assign win_cpu = cpu_req && (!dma_req || !rr_q);
    assign win_dma = dma_req && (!cpu_req ||  rr_q);
    assign win_op  = win_cpu ? cpu_opcode : dma_opcode;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        cpu_gnt_d  = 1'b0;
        dma_gnt_d  = 1'b0;
        cpu_done_d = 1'b0;
        dma_done_d = 1'b0;
        res_d      = res_q;
        fc_d       = fc_q;
        fz_d       = fz_q;

        unique case (state_q)
            IDLE: begin
                if (win_cpu || win_dma) begin
                    op_d      = win_op;
                    a_d       = win_cpu ? cpu_a : dma_a;
                    b_d       = win_cpu ? cpu_b : dma_b;
                    owner_d   = win_dma;
                    cnt_d     = (win_op == OP_MUL) ? MUL_LOAD : ALU_LOAD;
                    cpu_gnt_d = win_cpu;
                    dma_gnt_d = win_dma;
                    state_d   = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    res_d      = alu_result;
                    fc_d       = alu_flagC;
                    fz_d       = alu_flagZ;
                    rr_d       = ~owner_q;
                    cpu_done_d = ~owner_q;
                    dma_done_d =  owner_q;
                    state_d    = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            op_q       <= 3'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            owner_q    <= 1'b0;
            rr_q       <= 1'b0;
            cpu_gnt_q  <= 1'b0;
            dma_gnt_q  <= 1'b0;
            cpu_done_q <= 1'b0;
            dma_done_q <= 1'b0;
            res_q      <= 32'd0;
            fc_q       <= 1'b0;
            fz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            cpu_gnt_q  <= cpu_gnt_d;
            dma_gnt_q  <= dma_gnt_d;
            cpu_done_q <= cpu_done_d;
            dma_done_q <= dma_done_d;
            res_q      <= res_d;
            fc_q       <= fc_d;
            fz_q       <= fz_d;
        end
    end

    assign cpu_gnt    = cpu_gnt_q;
    assign dma_gnt    = dma_gnt_q;
    assign cpu_done   = cpu_done_q;
    assign dma_done   = dma_done_q;
    assign res        = res_q;
    assign flag_c     = fc_q;
    assign flag_z     = fz_q;
    assign busy       = (state_q != IDLE);
    assign alu_opcode = op_q;
    assign alu_op1    = a_q;
    assign alu_op2    = b_q;

endmodule
